// File: rtl/mdu_defs.sv
// Shared MD operation encodings and default busy-cycle counts for the E-stage multiply/divide unit.
package mdu_defs;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_compute.sv
// Purpose: combinational 64-bit mult/div result {hi, lo} from latched operands.
// Latency: zero cycles, purely combinational.
// Backpressure: none; wr_en is low for divide-by-zero so HI/LO keep their value.
module mdu_compute
    import mdu_defs::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        wr_en
);

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        is_signed_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        a_ext = (op == MD_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext = (op == MD_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = a_ext * b_ext;

        // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
        is_signed_div = (op == MD_DIV);
        a_neg  = is_signed_div & a[31];
        b_neg  = is_signed_div & b[31];
        a_mag  = a_neg ? (32'd0 - a) : a;
        b_mag  = b_neg ? (32'd0 - b) : b;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;

        result = 64'd0;
        wr_en  = 1'b0;
        if (is_mul_op(op)) begin
            result = prod;
            wr_en  = 1'b1;
        end else if ((op == MD_DIV) || (op == MD_DIVU)) begin
            result = {rem, quot};
            wr_en  = (b != 32'd0);
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Purpose: E-stage multiply/divide unit owning HI/LO, operand latches and busy counter.
// Latency: mult MULT_CYCLES, div DIV_CYCLES busy cycles; mfhi/mflo/mthi/mtlo single cycle when idle.
// Backpressure: md_stall holds any MD instruction while busy; a flush never cancels in-flight work.
module mdu_ctrl
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        start,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [63:0]      result;
    logic             res_wr_en;
    logic             is_md;
    logic             is_muldiv;

    assign is_md     = req_valid && (md_op != MD_NONE);
    assign is_muldiv = req_valid && is_muldiv_op(md_op);
    assign busy      = (cnt != '0);
    assign start     = is_muldiv && !busy;
    assign md_stall  = is_md && busy;
    assign md_rdata  = (md_op == MD_MFHI) ? hi : lo;

    mdu_compute u_compute (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (result),
        .wr_en  (res_wr_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= MD_NONE;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if ((cnt == CNT_W'(1)) && res_wr_en) begin
                hi <= result[63:32];
                lo <= result[31:0];
            end
        end else if (start) begin
            op_q <= md_op;
            a_q  <= rs_data;
            b_q  <= rt_data;
            cnt  <= is_mul_op(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (is_md) begin
            if (md_op == MD_MTHI) hi <= rs_data;
            if (md_op == MD_MTLO) lo <= rs_data;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_mdu_ctrl;

    localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3,
                           OP_DIVU = 4'd4, OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7,
                           OP_MTLO = 4'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        start;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;

    int total = 0;
    int bad = 0;

    // Behavioural model state: architectural HI/LO plus the result pending at the end of the busy window.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pwr;
    int          m_left;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .md_op     (md_op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .start     (start),
        .busy      (busy),
        .md_stall  (md_stall),
        .hi        (hi),
        .lo        (lo),
        .md_rdata  (md_rdata)
    );

    // Returns {write_enable, hi, lo} computed with 64-bit integer arithmetic.
    function automatic logic [64:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        logic [63:0]     pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == OP_MULT) begin
            pv = sa * sb;
            return {1'b1, pv};
        end
        if (op == OP_MULTU) begin
            p = ua * ub;
            return {1'b1, p};
        end
        if (b == 32'd0) return {1'b0, 64'd0};
        if (op == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
        end
        pv = {r[31:0], q[31:0]};
        return {1'b1, pv};
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        req_valid = v;
        md_op     = op;
        rs_data   = a;
        rt_data   = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, OP_NONE, 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Runs a started op through its busy window; returns how many cycles busy was seen high.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        total++; if ({start, md_stall} !== 2'b00) begin bad++; $display("FAIL reset_ctl got=%b exp=00", {start, md_stall}); end
        tick();
    endtask

    task automatic test_mult_mflo();
        drive(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3);
        @(negedge clk);
        total++; if ({start, md_stall} !== 2'b10) begin bad++; $display("FAIL mult_start got=%b exp=10", {start, md_stall}); end
        tick();
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if ({start, busy, md_stall} !== 3'b011) begin
                bad++; $display("FAIL mult_busy_T+%0d got=%b exp=011", k, {start, busy, md_stall});
            end
            tick();
        end
        @(negedge clk);
        total++; if ({busy, md_stall} !== 2'b00) begin bad++; $display("FAIL mult_done_ctl got=%b exp=00", {busy, md_stall}); end
        total++; if (lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        total++; if (md_rdata !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_mflo got=%h exp=fffffffa", md_rdata); end
        tick();
        drive(1'b0, OP_NONE, 32'd0, 32'd0);
    endtask

    task automatic test_div();
        logic [31:0] da[3] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] db[3] = '{32'd7, 32'd2, 32'hFFFF_FFFF};
        logic [3:0]  dop[3] = '{OP_DIVU, OP_DIV, OP_DIV};
        logic [31:0] elo[3] = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000};
        logic [31:0] ehi[3] = '{32'd2, 32'hFFFF_FFFF, 32'd0};
        int n;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, dop[i], da[i], db[i]);
            tick();
            drive(1'b0, OP_NONE, 32'd0, 32'd0);
            count_busy(n);
            total++; if (n != 10) begin bad++; $display("FAIL div%0d_busy got=%0d exp=10", i, n); end
            total++; if (lo !== elo[i]) begin bad++; $display("FAIL div%0d_lo got=%h exp=%h", i, lo, elo[i]); end
            total++; if (hi !== ehi[i]) begin bad++; $display("FAIL div%0d_hi got=%h exp=%h", i, hi, ehi[i]); end
        end
    endtask

    task automatic test_div_zero();
        int n;
        drive(1'b1, OP_MTHI, 32'h1234, 32'd0);
        tick();
        drive(1'b1, OP_MTLO, 32'h5678, 32'd0);
        tick();
        drive(1'b1, OP_DIV, 32'd55, 32'd0);
        tick();
        drive(1'b0, OP_NONE, 32'd0, 32'd0);
        count_busy(n);
        total++; if (n != 10) begin bad++; $display("FAIL div0_busy got=%0d exp=10", n); end
        total++; if (hi !== 32'h1234) begin bad++; $display("FAIL div0_hi got=%h exp=1234", hi); end
        total++; if (lo !== 32'h5678) begin bad++; $display("FAIL div0_lo got=%h exp=5678", lo); end
    endtask

    task automatic test_mthi_during_mult();
        drive(1'b1, OP_MULT, 32'd3, 32'd5);
        tick();
        drive(1'b1, OP_MTHI, 32'hAAAA, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++; if (md_stall !== 1'b1) begin bad++; $display("FAIL mthi_stall_T+%0d got=%b exp=1", k, md_stall); end
            tick();
        end
        @(negedge clk);
        total++; if (md_stall !== 1'b0) begin bad++; $display("FAIL mthi_release got=%b exp=0", md_stall); end
        total++; if ({hi, lo} !== {32'd0, 32'd15}) begin bad++; $display("FAIL mthi_mult_res got=%h exp=%h", {hi, lo}, {32'd0, 32'd15}); end
        tick();
        drive(1'b0, OP_NONE, 32'd0, 32'd0);
        @(negedge clk);
        total++; if ({hi, lo} !== {32'hAAAA, 32'd15}) begin bad++; $display("FAIL mthi_write got=%h exp=%h", {hi, lo}, {32'hAAAA, 32'd15}); end
        tick();
    endtask

    task automatic test_reset_mid_div();
        drive(1'b1, OP_MTHI, 32'h0BAD, 32'd0);
        tick();
        drive(1'b1, OP_DIVU, 32'd1000, 32'd3);
        tick();
        drive(1'b0, OP_NONE, 32'd0, 32'd0);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstdiv_busy got=%b exp=0", busy); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL rstdiv_hilo got=%h exp=0", {hi, lo}); end
        for (int i = 0; i < 12; i++) tick();
        @(negedge clk);
        total++; if ({busy, hi, lo} !== 65'd0) begin bad++; $display("FAIL rstdiv_late got=%h exp=0", {busy, hi, lo}); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        drive(1'b1, OP_MULTU, 32'd2, 32'd3);
        tick();
        drive(1'b1, OP_MULT, 32'd7, 32'd9);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++; if ({start, md_stall} !== 2'b01) begin bad++; $display("FAIL b2b_stall_T+%0d got=%b exp=01", k, {start, md_stall}); end
            tick();
        end
        @(negedge clk);
        total++; if ({start, md_stall} !== 2'b10) begin bad++; $display("FAIL b2b_start got=%b exp=10", {start, md_stall}); end
        total++; if (lo !== 32'd6) begin bad++; $display("FAIL b2b_first_lo got=%h exp=6", lo); end
        tick();
        drive(1'b0, OP_NONE, 32'd0, 32'd0);
        count_busy(n);
        total++; if (n != 5) begin bad++; $display("FAIL b2b_busy got=%0d exp=5", n); end
        total++; if ({hi, lo} !== {32'd0, 32'd63}) begin bad++; $display("FAIL b2b_second got=%h exp=%h", {hi, lo}, {32'd0, 32'd63}); end
    endtask

    task automatic test_random();
        logic        v, exp_start, exp_stall, exp_busy, muldiv;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [64:0] r;
        do_reset();
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_left = 0;
        for (int c = 0; c < 400; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 8));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(0, 3));
                1: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            drive(v, op, a, b);
            muldiv    = v && (op >= OP_MULT) && (op <= OP_DIVU);
            exp_busy  = (m_left > 0);
            exp_start = muldiv && !exp_busy;
            exp_stall = v && (op != OP_NONE) && exp_busy;
            @(negedge clk);
            total++;
            if ({start, busy, md_stall} !== {exp_start, exp_busy, exp_stall}) begin
                bad++; $display("FAIL rnd_ctl c=%0d got=%b exp=%b", c, {start, busy, md_stall}, {exp_start, exp_busy, exp_stall});
            end
            total++;
            if ({hi, lo} !== {m_hi, m_lo}) begin
                bad++; $display("FAIL rnd_hilo c=%0d got=%h exp=%h", c, {hi, lo}, {m_hi, m_lo});
            end
            if (v && !exp_busy && (op == OP_MFHI || op == OP_MFLO)) begin
                total++;
                if (md_rdata !== ((op == OP_MFHI) ? m_hi : m_lo)) begin
                    bad++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, md_rdata, (op == OP_MFHI) ? m_hi : m_lo);
                end
            end
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0 && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
            end else if (muldiv) begin
                r = ref_result(op, a, b);
                {m_pwr, m_phi, m_plo} = r;
                m_left = (op <= OP_MULTU) ? 5 : 10;
            end else if (v && op == OP_MTHI) begin
                m_hi = a;
            end else if (v && op == OP_MTLO) begin
                m_lo = a;
            end
            tick();
        end
        drive(1'b0, OP_NONE, 32'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_mult_mflo();
        test_div();
        test_div_zero();
        test_mthi_during_mult();
        test_reset_mid_div();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
